// File: rtl/bcd_scan_decoder.sv
// Multiplexed BCD-to-decimal decoder: snapshots NUM_DIGITS packed BCD digits and scans them
// one slot at a time, driving a registered active-low 1-of-10 decode and digit select.
module bcd_scan_decoder #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100000,
   parameter int LZB_EN     = 1,
   localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int PRE_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    scan_en,
   input  logic                    err_clr,
   output logic [9:0]              y_n,
   output logic [NUM_DIGITS-1:0]   dig_sel_n,
   output logic [IDX_W-1:0]        dig_idx,
   output logic                    frame_done,
   output logic                    err
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PRE_W-1:0] LastPre = PRE_W'(SCAN_DIV - 1);

   logic [4*NUM_DIGITS-1:0] snap_q;
   logic [PRE_W-1:0]        pre_q;
   logic [IDX_W-1:0]        idx_q;
   logic [9:0]              y_q, y_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic                    frame_q;
   logic                    err_q;
   logic                    tick;
   logic                    blank;
   logic                    bad_in;
   logic [3:0]              cur_digit;

   assign tick = scan_en && (pre_q == LastPre);

   // A slot is blank when it and every more-significant digit are zero; digit 0 always shows.
   always_comb begin
      cur_digit = snap_q[4*int'(idx_q) +: 4];
      blank     = (LZB_EN != 0) && (idx_q != '0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k >= int'(idx_q) && snap_q[4*k +: 4] != 4'd0) begin
            blank = 1'b0;
         end
      end
      if (blank || cur_digit > 4'd9) begin
         y_d = 10'h3FF;
      end else begin
         y_d = ~(10'b1 << cur_digit);
      end
      sel_d = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
   end

   always_comb begin
      bad_in = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd_in[4*k +: 4] > 4'd9) begin
            bad_in = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snap_q  <= '0;
         pre_q   <= '0;
         idx_q   <= '0;
         y_q     <= 10'h3FF;
         sel_q   <= '1;
         frame_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (load) begin
            snap_q <= bcd_in;
         end
         if (scan_en) begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
         end
         if (tick) begin
            idx_q <= (idx_q == LastIdx) ? '0 : idx_q + IDX_W'(1);
         end
         frame_q <= tick && (idx_q == LastIdx);
         y_q     <= y_d;
         sel_q   <= sel_d;
         // Setting wins over clearing when both happen on the same edge.
         if (load && bad_in) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

   assign y_n        = y_q;
   assign dig_sel_n  = sel_q;
   assign dig_idx    = idx_q;
   assign frame_done = frame_q;
   assign err        = err_q;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Directed bench for bcd_scan_decoder with 4 digits, a divide-by-4 prescaler and blanking on.
module tb_bcd_scan_decoder;

   logic        clk = 1'b0;
   logic        rst, load, scan_en, err_clr;
   logic [15:0] bcd_in;
   logic [9:0]  y_n;
   logic [3:0]  dig_sel_n;
   logic [1:0]  dig_idx;
   logic        frame_done, err;

   int checkCount = 0;
   int errCount   = 0;
   int pulses;

   bcd_scan_decoder #(.NUM_DIGITS(4), .SCAN_DIV(4), .LZB_EN(1)) dut (
      .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .scan_en(scan_en),
      .err_clr(err_clr), .y_n(y_n), .dig_sel_n(dig_sel_n), .dig_idx(dig_idx),
      .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench at the falling edge right after a frame wrap (idx 0, prescaler 0).
   task automatic applyStimulus_waitFrame();
      int budget;
      budget = 64;
      cycles(1);
      while (!frame_done && budget > 0) begin
         cycles(1);
         budget--;
      end
      if (!frame_done) checkOutput("frameTimeout", 16'd0, 16'd1);
   endtask

   task automatic checkSlot(input string tag, input logic [9:0] ey, input logic [3:0] es,
                            input logic [1:0] ei);
      checkOutput({tag, "_y"}, 16'(y_n), 16'(ey));
      checkOutput({tag, "_sel"}, 16'(dig_sel_n), 16'(es));
      checkOutput({tag, "_idx"}, 16'(dig_idx), 16'(ei));
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; scan_en = 1'b0; err_clr = 1'b0; bcd_in = 16'h0;
      cycles(3);
      checkSlot("reset", 10'h3FF, 4'hF, 2'd0);
      checkOutput("reset_fd", 16'(frame_done), 16'd0);
      checkOutput("reset_err", 16'(err), 16'd0);

      // 1234: slots show 4,3,2,1 at four cycles per slot.
      rst = 1'b0; load = 1'b1; bcd_in = 16'h1234; scan_en = 1'b1;
      cycles(1); load = 1'b0;
      cycles(1); checkSlot("d1234_0", 10'h3EF, 4'hE, 2'd0);
      cycles(3); checkSlot("d1234_1", 10'h3F7, 4'hD, 2'd1);
      cycles(4); checkSlot("d1234_2", 10'h3FB, 4'hB, 2'd2);
      cycles(4); checkSlot("d1234_3", 10'h3FD, 4'h7, 2'd3);
      cycles(2); checkOutput("fd_before", 16'(frame_done), 16'd0);
      cycles(1); checkOutput("fd_pulse", 16'(frame_done), 16'd1);
      checkOutput("fd_idx", 16'(dig_idx), 16'd0);
      cycles(1); checkOutput("fd_after", 16'(frame_done), 16'd0);
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         cycles(1);
         if (frame_done) pulses++;
      end
      checkOutput("fd_per16", 16'(pulses), 16'd1);

      // 0007: upper three slots blanked.
      applyStimulus_waitFrame();
      load = 1'b1; bcd_in = 16'h0007;
      cycles(1); load = 1'b0;
      cycles(1); checkSlot("d0007_0", 10'h37F, 4'hE, 2'd0);
      cycles(3); checkSlot("d0007_1", 10'h3FF, 4'hF, 2'd1);
      cycles(4); checkSlot("d0007_2", 10'h3FF, 4'hF, 2'd2);
      cycles(4); checkSlot("d0007_3", 10'h3FF, 4'hF, 2'd3);

      applyStimulus_waitFrame();
      load = 1'b1; bcd_in = 16'h0000;
      cycles(1); load = 1'b0;
      cycles(1); checkSlot("d0000_0", 10'h3FE, 4'hE, 2'd0);

      // 12A4: invalid nibble sets err, its slot decodes blank but stays selected.
      applyStimulus_waitFrame();
      load = 1'b1; bcd_in = 16'h12A4;
      cycles(1); load = 1'b0;
      checkOutput("err_set", 16'(err), 16'd1);
      cycles(4); checkSlot("d12A4_1", 10'h3FF, 4'hD, 2'd1);
      err_clr = 1'b1;
      cycles(1); err_clr = 1'b0;
      checkOutput("err_clr", 16'(err), 16'd0);
      err_clr = 1'b1; load = 1'b1; bcd_in = 16'hF000;
      cycles(1); err_clr = 1'b0; load = 1'b0;
      checkOutput("err_setwins", 16'(err), 16'd1);

      // Freeze two cycles into slot 0, then resume: two more cycles finish the slot.
      applyStimulus_waitFrame();
      cycles(2); scan_en = 1'b0;
      cycles(10); checkSlot("frozen", 10'h3FE, 4'hE, 2'd0);
      scan_en = 1'b1;
      cycles(1); checkOutput("resume_hold", 16'(dig_idx), 16'd0);
      cycles(1); checkOutput("resume_adv", 16'(dig_idx), 16'd1);

      // Reset mid-slot at idx 2; err must clear too.
      applyStimulus_waitFrame();
      load = 1'b1; bcd_in = 16'h1234;
      cycles(1); load = 1'b0;
      cycles(9); checkOutput("pre_rst_idx", 16'(dig_idx), 16'd2);
      rst = 1'b1;
      cycles(1); rst = 1'b0;
      checkSlot("midrst", 10'h3FF, 4'hF, 2'd0);
      checkOutput("midrst_fd", 16'(frame_done), 16'd0);
      checkOutput("midrst_err", 16'(err), 16'd0);
      cycles(3); checkOutput("rst_idx0", 16'(dig_idx), 16'd0);
      cycles(1); checkOutput("rst_idx1", 16'(dig_idx), 16'd1);
      cycles(1); checkSlot("rst_blank1", 10'h3FF, 4'hF, 2'd1);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
